cd_pila: RTL

Parametrised single-cycle datapath with a hardware return-address stack. It executes one instruction per `clk` from an external, combinationally read program memory. It contains the PC, a 16-entry register file, the ALU, the immediate mux, the Z flag and a LIFO of return addresses for subroutine call and return. It is driven by the existing control unit extended with `s_call` and `s_ret`, and sits where the fixed 10-bit datapath sits in the CPU top level.

---
 rtl/cd_pila_if.sv | 39 +++
 rtl/cd_pila.sv | 138 +++++++++++++
 2 files changed

// File: rtl/cd_pila_if.sv
`default_nettype none
// ============================================================================
// Module      : cd_pila_if
// Description : Control/status bundle between the control unit and the
//               cd_pila datapath: instruction word, datapath controls and
//               the PC, opcode, flag and return-stack status coming back.
// Revision    : 1.0 - initial release
// ============================================================================
interface cd_pila_if #(
  parameter int PC_W        = 10,
  parameter int STACK_DEPTH = 8
);
  logic [15:0]                          instr;
  logic                                 s_inc;
  logic                                 s_inm;
  logic                                 we3;
  logic                                 wez;
  logic [2:0]                           op_alu;
  logic                                 s_call;
  logic                                 s_ret;
  logic [PC_W-1:0]                      pc;
  logic [5:0]                           opcode;
  logic                                 z;
  logic [$clog2(STACK_DEPTH+1)-1:0]     sp_count;
  logic                                 stk_err;

  // Control unit / program memory side
  modport master (
    output instr, s_inc, s_inm, we3, wez, op_alu, s_call, s_ret,
    input  pc, opcode, z, sp_count, stk_err
  );

  // Datapath side
  modport slave (
    input  instr, s_inc, s_inm, we3, wez, op_alu, s_call, s_ret,
    output pc, opcode, z, sp_count, stk_err
  );
endinterface
`default_nettype wire

// File: rtl/cd_pila.sv
`default_nettype none
// ============================================================================
// Module      : cd_pila
// Description : Single-cycle datapath (PC, 16-entry register file, ALU,
//               immediate mux, Z flag) with a hardware return-address stack
//               for subroutine call/return.
//               Define CD_STACK_CHECK_EN to enable overflow/underflow
//               detection with a sticky stk_err flag; when undefined the
//               stack pointer wraps and stk_err is tied low.
// Revision    : 1.0 - initial release
// ============================================================================
module cd_pila #(
  parameter int PC_W        = 10,
  parameter int DATA_W      = 8,
  parameter int STACK_DEPTH = 8
) (
  input  wire logic clk,
  input  wire logic reset,
  cd_pila_if.slave  bus
);

  localparam int                c_SP_W     = $clog2(STACK_DEPTH + 1);
  localparam int                c_AW       = $clog2(STACK_DEPTH);
  localparam logic [c_SP_W-1:0] c_DEPTH    = c_SP_W'(STACK_DEPTH);
  localparam logic [c_SP_W-1:0] c_DEPTH_M1 = c_SP_W'(STACK_DEPTH - 1);

  logic [PC_W-1:0]   r_pc;
  logic              r_z;
  logic [c_SP_W-1:0] r_sp;
  logic [DATA_W-1:0] r_rf    [16];
  logic [PC_W-1:0]   r_stack [STACK_DEPTH];

  logic [3:0]        w_ra1, w_ra2, w_wa;
  logic [DATA_W-1:0] w_a, w_b, w_alu, w_wdata;
  logic [PC_W-1:0]   w_target, w_pc_inc, w_pc_next;
  logic              w_push, w_pop;
  logic [c_SP_W-1:0] w_sp_inc, w_sp_dec;
  logic [c_AW-1:0]   w_push_idx, w_pop_idx;

  assign w_ra1    = bus.instr[11:8];
  assign w_ra2    = bus.instr[7:4];
  assign w_wa     = bus.instr[3:0];
  assign w_target = bus.instr[PC_W-1:0];
  assign w_pc_inc = r_pc + PC_W'(1);

  // Register 0 is hard-wired to zero on both read ports
  assign w_a = (w_ra1 == 4'd0) ? '0 : r_rf[w_ra1];
  assign w_b = (w_ra2 == 4'd0) ? '0 : r_rf[w_ra2];

  // ALU: results are naturally truncated to DATA_W
  always_comb begin
    w_alu = w_a;
    case (bus.op_alu)
      3'b000:  w_alu = w_a;
      3'b001:  w_alu = ~w_a;
      3'b010:  w_alu = w_a + w_b;
      3'b011:  w_alu = w_a - w_b;
      3'b100:  w_alu = w_a & w_b;
      3'b101:  w_alu = w_a | w_b;
      3'b110:  w_alu = '0 - w_a;
      default: w_alu = '0 - w_b;
    endcase
  end

  assign w_wdata = bus.s_inm ? DATA_W'(bus.instr[11:4]) : w_alu;

`ifdef CD_STACK_CHECK_EN
  logic r_err;
  logic w_ovf, w_unf;

  // Return has priority, so a combined call+return can only underflow
  assign w_ovf    = bus.s_call & ~bus.s_ret & (r_sp == c_DEPTH);
  assign w_unf    = bus.s_ret & (r_sp == '0);
  assign w_push   = bus.s_call & ~bus.s_ret & ~w_ovf;
  assign w_pop    = bus.s_ret & ~w_unf;
  assign w_sp_inc = r_sp + c_SP_W'(1);
  assign w_sp_dec = r_sp - c_SP_W'(1);

  // Sticky stack error, cleared only by reset
  always_ff @(posedge clk) begin
    if (reset) r_err <= 1'b0;
    else       r_err <= r_err | w_ovf | w_unf;
  end

  assign bus.stk_err = r_err;
`else
  // Unchecked stack: the pointer wraps modulo the depth
  assign w_push   = bus.s_call & ~bus.s_ret;
  assign w_pop    = bus.s_ret;
  assign w_sp_inc = (r_sp == c_DEPTH_M1) ? '0 : r_sp + c_SP_W'(1);
  assign w_sp_dec = (r_sp == '0) ? c_DEPTH_M1 : r_sp - c_SP_W'(1);

  assign bus.stk_err = 1'b0;
`endif

  // Push and pop only address entries below STACK_DEPTH, so the low bits suffice
  assign w_push_idx = r_sp[c_AW-1:0];
  assign w_pop_idx  = w_sp_dec[c_AW-1:0];

  // Next-PC priority: return, call, increment, jump; a failed pop falls through to PC+1
  always_comb begin
    w_pc_next = w_target;
    if (bus.s_ret)       w_pc_next = w_pop ? r_stack[w_pop_idx] : w_pc_inc;
    else if (bus.s_call) w_pc_next = w_target;
    else if (bus.s_inc)  w_pc_next = w_pc_inc;
  end

  // PC, Z flag and stack pointer
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc <= '0;
      r_z  <= 1'b0;
      r_sp <= '0;
    end else begin
      r_pc <= w_pc_next;
      if (bus.wez) r_z <= (w_alu == '0);
      if (w_push)     r_sp <= w_sp_inc;
      else if (w_pop) r_sp <= w_sp_dec;
    end
  end

  // Register file write port; contents are not reset, register 0 never written
  always_ff @(posedge clk) begin
    if (!reset && bus.we3 && (w_wa != 4'd0)) r_rf[w_wa] <= w_wdata;
  end

  // Return-address storage; contents are not reset
  always_ff @(posedge clk) begin
    if (!reset && w_push) r_stack[w_push_idx] <= w_pc_inc;
  end

  assign bus.pc       = r_pc;
  assign bus.opcode   = bus.instr[15:10];
  assign bus.z        = r_z;
  assign bus.sp_count = r_sp;

endmodule
`default_nettype wire
